// File: rtl/waffle_pkg.sv
// Shared defaults and types for the waffle sequencer slice.
package waffle_pkg;

  localparam int unsigned IMG_ROWS_DEF = 16;
  localparam int unsigned IMG_COLS_DEF = 16;
  localparam int unsigned PIX_W_DEF    = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    SOLVE,
    HOLD
  } seq_state_t;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/waffle_frame_buffer.sv
// Row-addressed frame store: one row written per cycle, whole frame readable.
module waffle_frame_buffer
  import waffle_pkg::*;
#(
  parameter int unsigned ROWS  = IMG_ROWS_DEF,
  parameter int unsigned COLS  = IMG_COLS_DEF,
  parameter int unsigned PIX_W = PIX_W_DEF,
  localparam int unsigned ROW_W  = $clog2(ROWS),
  localparam int unsigned LINE_W = COLS * PIX_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [ROW_W-1:0]                       wr_row,
  input  logic [LINE_W-1:0]                      wr_data,
  output logic [ROWS-1:0][COLS-1:0][PIX_W-1:0]   frame
);

  // Rows not being written keep their contents, so an old frame stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
    end else if (wr_en) begin
      frame[wr_row] <= wr_data;
    end
  end

endmodule

// File: rtl/waffle_sequencer.sv
// Fetches a frame row-by-row into a local buffer, lets the solver settle for
// one cycle, and returns the registered result over valid/ready.
module waffle_sequencer
  import waffle_pkg::*;
#(
  parameter int unsigned IMG_ROWS = IMG_ROWS_DEF,
  parameter int unsigned IMG_COLS = IMG_COLS_DEF,
  parameter int unsigned PIX_W    = PIX_W_DEF,
  localparam int unsigned ROW_W   = $clog2(IMG_ROWS),
  localparam int unsigned LINE_W  = IMG_COLS * PIX_W
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         mem_rd_en,
  output logic [ROW_W-1:0]                             mem_rd_row,
  input  logic [LINE_W-1:0]                            mem_rd_data,
  output logic [IMG_ROWS-1:0][IMG_COLS-1:0][PIX_W-1:0] solver_image,
  input  logic [31:0]                                  solver_result,
  output logic [31:0]                                  result,
  output logic                                         result_valid,
  input  logic                                         result_ready
);

  seq_state_t        state, state_n;
  logic [ROW_W-1:0]  req_row_n;
  logic              rd_en_n;
  logic              busy_n;
  logic [31:0]       result_n;
  logic              result_valid_n;
  logic              cap_valid;
  logic [ROW_W-1:0]  cap_row;

  // The request row register doubles as the memory address output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_rd_row   <= '0;
      mem_rd_en    <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      mem_rd_row   <= req_row_n;
      mem_rd_en    <= rd_en_n;
      busy         <= busy_n;
      result       <= result_n;
      result_valid <= result_valid_n;
    end
  end

  always_comb begin
    state_n        = state;
    req_row_n      = mem_rd_row;
    result_n       = result;
    result_valid_n = result_valid;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = FETCH;
          req_row_n = '0;
        end
      end
      FETCH: begin
        if (mem_rd_row == ROW_W'(IMG_ROWS - 1)) begin
          state_n = DRAIN;
        end else begin
          req_row_n = mem_rd_row + ROW_W'(1);
        end
      end
      DRAIN: state_n = SOLVE;
      SOLVE: begin
        result_n       = solver_result;
        result_valid_n = 1'b1;
        state_n        = HOLD;
      end
      HOLD: begin
        if (result_ready) begin
          result_valid_n = 1'b0;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    rd_en_n = (state_n == FETCH);
    busy_n  = (state_n != IDLE);
  end

  // Read data lags the request by one cycle; this delay aligns the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_row   <= '0;
    end else begin
      cap_valid <= mem_rd_en;
      cap_row   <= mem_rd_row;
    end
  end

  waffle_frame_buffer #(
    .ROWS  (IMG_ROWS),
    .COLS  (IMG_COLS),
    .PIX_W (PIX_W)
  ) u_frame_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_valid),
    .wr_row  (cap_row),
    .wr_data (mem_rd_data),
    .frame   (solver_image)
  );

endmodule

// File: tb/tb_waffle_sequencer.sv
// Directed bench for waffle_sequencer with a row RAM model and a pixel-sum solver stub.
module tb_waffle_sequencer;

  localparam int unsigned R = 16;
  localparam int unsigned C = 16;
  localparam int unsigned P = 32;

  logic                         clk;
  logic                         rst_n;
  logic                         start;
  logic                         busy;
  logic                         mem_rd_en;
  logic [3:0]                   mem_rd_row;
  logic [C*P-1:0]               mem_rd_data;
  logic [R-1:0][C-1:0][P-1:0]   solver_image;
  logic [31:0]                  solver_result;
  logic [31:0]                  result;
  logic                         result_valid;
  logic                         result_ready;

  logic [C*P-1:0] mem [R];

  int errors;
  int checks;

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_en;
    logic [3:0]  exp_row;
    logic        exp_busy;
    logic        exp_valid;
    logic [31:0] exp_result;
  } vec_t;

  vec_t tbl [22];

  waffle_sequencer #(
    .IMG_ROWS (R),
    .IMG_COLS (C),
    .PIX_W    (P)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_row    (mem_rd_row),
    .mem_rd_data   (mem_rd_data),
    .solver_image  (solver_image),
    .solver_result (solver_result),
    .result        (result),
    .result_valid  (result_valid),
    .result_ready  (result_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read row RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_row];
  end

  always_comb begin
    solver_result = '0;
    for (int r = 0; r < int'(R); r++)
      for (int c = 0; c < int'(C); c++)
        solver_result = solver_result + solver_image[r][c];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < int'(R); r++)
      for (int c = 0; c < int'(C); c++)
        mem[r][c*P +: P] = 32'(r * 16 + c);
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int r = 0; r < int'(R); r++)
      for (int c = 0; c < int'(C); c++)
        mem[r][c*P +: P] = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    check({tag, "_rd_row"}, 32'(mem_rd_row), 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_valid"}, 32'(result_valid), 0);
    check({tag, "_image"}, 32'(solver_image != '0), 0);
  endtask

  initial begin
    int reads;
    int valids;
    clk = 1'b0;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    start = 1'b0;
    result_ready = 1'b0;
    mem_rd_data = '0;
    fill_ramp();

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Basic solve: per-cycle expectations relative to the start cycle.
    for (int k = 0; k < 22; k++) begin
      tbl[k].start      = (k == 0);
      tbl[k].ready      = 1'b1;
      tbl[k].exp_en     = (k >= 1 && k <= 16);
      tbl[k].exp_row    = (k >= 1 && k <= 16) ? 4'(k - 1) : 4'd0;
      tbl[k].exp_busy   = (k >= 1 && k <= 19);
      tbl[k].exp_valid  = (k == 19);
      tbl[k].exp_result = (k >= 19) ? 32'd32640 : 32'd0;
    end
    for (int k = 0; k < 22; k++) begin
      check($sformatf("basic_en_c%0d", k), 32'(mem_rd_en), 32'(tbl[k].exp_en));
      if (tbl[k].exp_en)
        check($sformatf("basic_row_c%0d", k), 32'(mem_rd_row), 32'(tbl[k].exp_row));
      check($sformatf("basic_busy_c%0d", k), 32'(busy), 32'(tbl[k].exp_busy));
      check($sformatf("basic_valid_c%0d", k), 32'(result_valid), 32'(tbl[k].exp_valid));
      check($sformatf("basic_result_c%0d", k), result, tbl[k].exp_result);
      start = tbl[k].start;
      result_ready = tbl[k].ready;
      step();
    end
    start = 1'b0;

    // Backpressure: valid held for 10 cycles with ready low.
    result_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (18) step();
    check("bp_valid_c19", 32'(result_valid), 1);
    check("bp_result_c19", result, 32'd32640);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp_hold_valid_%0d", i), 32'(result_valid), 1);
      check($sformatf("bp_hold_result_%0d", i), result, 32'd32640);
      check($sformatf("bp_hold_busy_%0d", i), 32'(busy), 1);
      check($sformatf("bp_hold_rd_en_%0d", i), 32'(mem_rd_en), 0);
    end
    result_ready = 1'b1;
    step();
    check("bp_release_busy", 32'(busy), 0);
    check("bp_release_valid", 32'(result_valid), 0);
    check("bp_release_result", result, 32'd32640);

    // Start while busy: pulses in cycles 5 and 19 must be ignored.
    reads = 0;
    valids = 0;
    start = 1'b1;
    for (int k = 1; k < 30; k++) begin
      step();
      if (mem_rd_en) reads++;
      if (result_valid) valids++;
      start = (k == 5 || k == 19);
    end
    start = 1'b0;
    check("swb_reads", 32'(reads), 16);
    check("swb_results", 32'(valids), 1);
    check("swb_idle", 32'(busy), 0);
    step();

    // Back-to-back frames at the minimum start-to-start period.
    fill_const(32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (18) step();
    check("b2b_a_valid", 32'(result_valid), 1);
    check("b2b_a_result", result, 32'd256);
    fill_const(32'd2);
    step();
    check("b2b_idle_busy", 32'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_b_first_en", 32'(mem_rd_en), 1);
    check("b2b_b_first_row", 32'(mem_rd_row), 0);
    repeat (18) step();
    check("b2b_b_valid", 32'(result_valid), 1);
    check("b2b_b_result", result, 32'd512);
    step();

    // Reset mid-fetch, then a clean frame with a different fill value.
    fill_const(32'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("rst_pre_en", 32'(mem_rd_en), 1);
    check("rst_pre_row", 32'(mem_rd_row), 7);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("rst_after");
    fill_const(32'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (18) step();
    check("rst_new_valid", 32'(result_valid), 1);
    check("rst_new_result", result, 32'd768);
    step();
    check("rst_new_done", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/waffle_sequencer.md
# waffle_sequencer

Sequential front-end for the combinational `waffle_solver`. It fetches one image row per cycle from a row-wide memory read port and assembles the full frame in a local buffer. It then presents the frame to the solver for one settle cycle, registers the solver's result and returns it over a valid/ready handshake. It replaces the direct whole-memory wiring with a single narrow memory port, so image memory can be a real RAM.

## Interface
- `IMG_ROWS`, 16, image rows (≥2)
- `IMG_COLS`, 16, image columns
- `PIX_W`, 32, bits per pixel
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request to solve the frame currently in memory; accepted only when `busy`=0
- `busy`  out  1  high in every state except IDLE
- `mem_rd_en`  out  1  row read strobe
- `mem_rd_row`  out  $clog2(IMG_ROWS)  row address; meaningful only when `mem_rd_en`=1
- `mem_rd_data`  in  IMG_COLS*PIX_W  row data, valid exactly 1 cycle after `mem_rd_en`; column c at bits [c*PIX_W +: PIX_W]
- `solver_image`  out  [IMG_ROWS][IMG_COLS][PIX_W]  frame buffer contents, drives `waffle_solver.memory_input`
- `solver_result`  in  32  `waffle_solver.result` (combinational from `solver_image`)
- `result`  out  32  registered solver result
- `result_valid`  out  1  `result` is valid
- `result_ready`  in  1  consumer accepts `result`

## Operation
- States: IDLE, FETCH, DRAIN, SOLVE, HOLD.
- IDLE: `busy`=0. If `start`=1, the FSM goes to FETCH, clears `req_row` and sets `cap_valid`=0.
- FETCH: `mem_rd_en`=1 and `mem_rd_row`=`req_row`. `req_row` increments each cycle. After the request for row IMG_ROWS-1 the FSM goes to DRAIN. There is no wrap; the counter never exceeds IMG_ROWS-1.
- Capture: a 1-cycle-delayed copy of (`mem_rd_en`, `mem_rd_row`) writes `mem_rd_data` into the frame buffer row at the delayed address.
  - Capture runs in FETCH and DRAIN.
  - No other frame-buffer writes occur.
  - Rows are overwritten in place; a previous frame stays visible until overwritten.
- DRAIN: one cycle, captures row IMG_ROWS-1, then the FSM goes to SOLVE.
- SOLVE: one cycle with the frame buffer stable. At the end of the cycle `result` ← `solver_result`, `result_valid` ← 1, and the FSM goes to HOLD.
- HOLD: `result` and `result_valid` are held stable. When `result_valid` and `result_ready` are both 1, `result_valid` ← 0 and the FSM goes to IDLE.
- `result_ready` is ignored outside HOLD.
- `start` is ignored while `busy`=1, including in the HOLD handshake cycle. It is not queued.
- `result` keeps its last value after the handshake. It changes only in SOLVE.

## Timing
- Reset (async, `rst_n`=0): the FSM enters IDLE.
  - Reset values of outputs: `busy`=0, `mem_rd_en`=0, `mem_rd_row`=0, `result`=0, `result_valid`=0, `solver_image`=all 0.
  - Counters and the capture delay register are cleared.
- Reset mid-operation aborts immediately. Partially captured rows are cleared and no result is produced.
- `start` high in cycle 0 (sampled at the end of cycle 0) gives this sequence:
  - `mem_rd_en`=1 in cycles 1..IMG_ROWS, with row k in cycle k+1.
  - Row k data arrives in cycle k+2.
  - DRAIN is cycle IMG_ROWS+1.
  - SOLVE is cycle IMG_ROWS+2.
  - `result_valid`=1 from cycle IMG_ROWS+3.
- For 16 rows: 16 consecutive reads, and `result_valid` first high in cycle 19.
- Minimum start-to-start period is IMG_ROWS+4 cycles (one HOLD cycle with `result_ready`=1, then one IDLE cycle).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `waffle_pkg`:
  - `IMG_ROWS_DEF`/`IMG_COLS_DEF`/`PIX_W_DEF` = 16/16/32
  - `seq_state_t` enum {IDLE, FETCH, DRAIN, SOLVE, HOLD}
  - `pixel_t` = logic [PIX_W_DEF-1:0]
- Sub-module `waffle_frame_buffer`: IMG_ROWS×row registers with async clear, a write port (`wr_en`, `wr_row`, `wr_data`) and a full-frame read output.
- The FSM, counters and result register live in `waffle_sequencer`.

## Test plan
- **Basic solve.** Memory row r, column c = r*16+c. Stub solver returns the pixel sum. Pulse `start`; `result_ready`=1.
  - Required: `mem_rd_row` 0..15 in cycles 1..16.
  - Required: `result`=32640 with `result_valid` rising in cycle 19, for exactly 1 cycle.
- **Backpressure.** Same stimulus, `result_ready` held 0 for 10 cycles after valid.
  - Required: `result`/`result_valid` stable throughout, `busy`=1, and no further reads.
  - Required: IDLE one cycle after `result_ready` rises.
- **Start while busy.** Pulse `start` in cycles 5 and 19 of a run.
  - Required: exactly 16 reads total and one result; the second pulse has no effect.
- **Back-to-back frames.** Frame A is all 1 (sum 256). Memory changes to all 2 before the second `start` (sum 512).
  - Required: results 256 then 512.
  - Required: the second `mem_rd_en` burst starts in the cycle after the `start` sampled in IDLE.
- **Reset mid-fetch.** Assert `rst_n`=0 in cycle 8.
  - Required: all outputs 0 immediately and `solver_image` all 0.
  - Required: after release, a new `start` yields a correct result with no stale rows.
